// File: rtl/wr_ctrl_flags.sv
// Write-side controller for the async FIFO: binary/Gray write pointers, registered full,
// programmable almost-full, fill level, write acknowledge and sticky overflow.
module wr_ctrl_flags #(
    parameter int ADDR_SIZE = 4
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE:0]   wq2_ptr,
    input  logic [ADDR_SIZE:0]   af_thresh,
    input  logic                 clr_ovf,
    output logic                 mem_we,
    output logic [ADDR_SIZE-1:0] wr_ptr,
    output logic [ADDR_SIZE:0]   wr_ptr_gray,
    output logic                 full,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   wr_level,
    output logic                 wr_ack,
    output logic                 overflow
);
    localparam int A = ADDR_SIZE;
    localparam logic [A:0] DEPTH = {1'b1, {A{1'b0}}};

    logic [A:0] wbin;
    logic [A:0] wbin_next;
    logic [A:0] wgray_next;
    logic [A:0] rbin_s;
    logic [A:0] level_next;
    logic [A:0] thr;
    logic [A:0] full_cmp;
    logic       push;

    assign push       = wr_en & ~full;
    assign mem_we     = push;
    assign wr_ptr     = wbin[A-1:0];
    assign wbin_next  = wbin + {{A{1'b0}}, push};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= A; i++) begin
            rbin_s[i] = ^(wq2_ptr >> i);
        end
    end

    assign level_next = wbin_next - rbin_s;
    assign thr        = (af_thresh == '0 || af_thresh > DEPTH) ? DEPTH : af_thresh;
    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_cmp   = {~wq2_ptr[A:A-1], wq2_ptr[A-2:0]};

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            wbin        <= '0;
            wr_ptr_gray <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            wr_ack      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wr_ptr_gray <= wgray_next;
            full        <= (wgray_next == full_cmp);
            almost_full <= (level_next >= thr);
            wr_level    <= level_next;
            wr_ack      <= push;
            if (wr_en & full)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_wr_ctrl_flags.sv
// Directed bench for wr_ctrl_flags with ADDR_SIZE=4 (DEPTH=16).
module tb_wr_ctrl_flags;
    logic       wr_clk;
    logic       wr_rst;
    logic       wr_en;
    logic [4:0] wq2_ptr;
    logic [4:0] af_thresh;
    logic       clr_ovf;
    logic       mem_we;
    logic [3:0] wr_ptr;
    logic [4:0] wr_ptr_gray;
    logic       full;
    logic       almost_full;
    logic [4:0] wr_level;
    logic       wr_ack;
    logic       overflow;

    int errors = 0;
    int checks = 0;

    wr_ctrl_flags #(.ADDR_SIZE(4)) dut (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .wr_en(wr_en), .wq2_ptr(wq2_ptr),
        .af_thresh(af_thresh), .clr_ovf(clr_ovf), .mem_we(mem_we), .wr_ptr(wr_ptr),
        .wr_ptr_gray(wr_ptr_gray), .full(full), .almost_full(almost_full),
        .wr_level(wr_level), .wr_ack(wr_ack), .overflow(overflow)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    function automatic logic [4:0] g(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        wr_rst = 1'b1;
        wr_en = 1'b0;
        clr_ovf = 1'b0;
        tick();
        wr_rst = 1'b0;
    endtask

    task automatic test_reset();
        wr_rst = 1'b0; wr_en = 1'b0; wq2_ptr = '0; af_thresh = '0; clr_ovf = 1'b0;
        @(posedge wr_clk);
        #3;
        wr_rst = 1'b1;
        #1;
        checks++;
        if ({mem_we, wr_ptr, wr_ptr_gray, full, almost_full, wr_level, wr_ack, overflow} !== 19'd0) begin
            errors++;
            $display("FAIL reset_async outputs=%h expected 0", {mem_we, wr_ptr, wr_ptr_gray, full, almost_full, wr_level, wr_ack, overflow});
        end
        tick();
        wr_rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if ({mem_we, wr_ptr, wr_ptr_gray, full, almost_full, wr_level, wr_ack, overflow} !== 19'd0) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d outputs=%h expected 0", c, {mem_we, wr_ptr, wr_ptr_gray, full, almost_full, wr_level, wr_ack, overflow});
            end
        end
    endtask

    task automatic fill16();
        wq2_ptr = '0;
        wr_en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            checks++;
            if (wr_ack !== 1'b1 || wr_level !== 5'(k) || wr_ptr !== 4'(k) ||
                wr_ptr_gray !== g(5'(k)) || full !== (k == 16) || almost_full !== (k == 16)) begin
                errors++;
                $display("FAIL fill k=%0d ack=%b lvl=%0d ptr=%0d gray=%b full=%b af=%b expected ack=1 lvl=%0d ptr=%0d gray=%b full=%b af=%b",
                         k, wr_ack, wr_level, wr_ptr, wr_ptr_gray, full, almost_full,
                         k, k % 16, g(5'(k)), k == 16, k == 16);
            end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_fill();
        af_thresh = '0;
        fill16();
        checks++;
        if (full !== 1'b1 || almost_full !== 1'b1 || wr_level !== 5'd16 ||
            wr_ptr_gray !== 5'b11000 || wr_ptr !== 4'd0) begin
            errors++;
            $display("FAIL full_state full=%b af=%b lvl=%0d gray=%b ptr=%0d expected 1 1 16 11000 0",
                     full, almost_full, wr_level, wr_ptr_gray, wr_ptr);
        end
    endtask

    task automatic test_overflow();
        wr_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL ovf_mem_we cyc=%0d mem_we=%b expected 0", c, mem_we);
            end
            tick();
            checks++;
            if (overflow !== 1'b1 || wr_ack !== 1'b0 || wr_ptr_gray !== 5'b11000 ||
                wr_ptr !== 4'd0 || wr_level !== 5'd16 || full !== 1'b1) begin
                errors++;
                $display("FAIL ovf_hold cyc=%0d ovf=%b ack=%b gray=%b ptr=%0d lvl=%0d full=%b expected 1 0 11000 0 16 1",
                         c, overflow, wr_ack, wr_ptr_gray, wr_ptr, wr_level, full);
            end
        end
        clr_ovf = 1'b1;
        tick();
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set_wins ovf=%b expected 1", overflow);
        end
        wr_en = 1'b0;
        tick();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear ovf=%b expected 0", overflow);
        end
        clr_ovf = 1'b0;
    endtask

    task automatic test_almost_full();
        do_reset();
        af_thresh = 5'd12;
        wq2_ptr = '0;
        wr_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks++;
            if (wr_level !== 5'(k) || almost_full !== (k >= 12)) begin
                errors++;
                $display("FAIL af_rise k=%0d lvl=%0d af=%b expected lvl=%0d af=%b", k, wr_level, almost_full, k, k >= 12);
            end
        end
        wr_en = 1'b0;
        wq2_ptr = 5'b00010;
        tick();
        checks++;
        if (wr_level !== 5'd9 || almost_full !== 1'b0) begin
            errors++;
            $display("FAIL af_read lvl=%0d af=%b expected 9 0", wr_level, almost_full);
        end
        af_thresh = 5'd20;
        tick();
        checks++;
        if (almost_full !== 1'b0) begin
            errors++;
            $display("FAIL af_over_depth af=%b expected 0", almost_full);
        end
        af_thresh = 5'd9;
        tick();
        checks++;
        if (almost_full !== 1'b1) begin
            errors++;
            $display("FAIL af_equal af=%b expected 1", almost_full);
        end
    endtask

    task automatic test_wrap();
        logic [4:0] wb;
        logic [4:0] prev_gray;
        logic       wrapped;
        do_reset();
        af_thresh = '0;
        wq2_ptr = '0;
        wr_en = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        wb = 5'd4;
        wrapped = 1'b0;
        prev_gray = wr_ptr_gray;
        for (int k = 0; k < 40; k++) begin
            wq2_ptr = g(wb - 5'd4);
            tick();
            wb = wb + 5'd1;
            if (wb == 5'd0) wrapped = 1'b1;
            checks++;
            if (wr_level !== 5'd5 || full !== 1'b0 || $countones(wr_ptr_gray ^ prev_gray) != 1 ||
                wr_ptr_gray !== g(wb) || wr_ptr !== wb[3:0]) begin
                errors++;
                $display("FAIL wrap k=%0d lvl=%0d full=%b gray=%b prev=%b ptr=%0d expected lvl=5 full=0 gray=%b ptr=%0d",
                         k, wr_level, full, wr_ptr_gray, prev_gray, wr_ptr, g(wb), wb[3:0]);
            end
            prev_gray = wr_ptr_gray;
        end
        wr_en = 1'b0;
        wq2_ptr = g(wb - 5'd4);
        tick();
        checks++;
        if (wr_level !== 5'd4 || wrapped !== 1'b1) begin
            errors++;
            $display("FAIL wrap_idle lvl=%0d wrapped=%b expected 4 1", wr_level, wrapped);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        af_thresh = '0;
        fill16();
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre full=%b ovf=%b expected 1 1", full, overflow);
        end
        #3;
        wr_rst = 1'b1;
        #1;
        checks++;
        if ({mem_we, wr_ptr, wr_ptr_gray, full, almost_full, wr_level, wr_ack, overflow} !== 19'd0) begin
            errors++;
            $display("FAIL mid_reset outputs=%h expected 0", {mem_we, wr_ptr, wr_ptr_gray, full, almost_full, wr_level, wr_ack, overflow});
        end
        #2;
        wr_rst = 1'b0;
        tick();
        wr_en = 1'b1;
        #1;
        checks++;
        if (wr_ptr !== 4'd0 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL mid_first_addr ptr=%0d mem_we=%b expected 0 1", wr_ptr, mem_we);
        end
        tick();
        wr_en = 1'b0;
        checks++;
        if (wr_ack !== 1'b1 || wr_ptr !== 4'd1 || wr_level !== 5'd1) begin
            errors++;
            $display("FAIL mid_first_ack ack=%b ptr=%0d lvl=%0d expected 1 1 1", wr_ack, wr_ptr, wr_level);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_almost_full();
        test_wrap();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
